// File: rtl/fetch0_pc.sv
// fetch0_pc: fetch PC sequencer and I-cache front end.
// Issues in-order I-cache requests under a credit limit of DEPTH, discards
// responses made stale by kills/redirects, and buffers surviving instructions
// in a DEPTH-entry FIFO presented to decode via valid/ready.
// Optional feature: define FE_IFAULT_EN to carry I-cache access faults to
// decode on fe_exc and halt issue after a faulting instruction is buffered.
module fetch0_pc #(
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        csr_kill,
  input  logic        csr_fe_inhibit,
  input  logic        csr_setpc,
  input  logic [29:0] csr_newpc,
  input  logic        ex_redirect,
  input  logic [29:0] ex_target,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [29:0] ic_req_pc,
  input  logic        ic_rsp_valid,
  input  logic [31:0] ic_rsp_data,
  input  logic        ic_rsp_fault,
  output logic        fe_valid,
  input  logic        fe_ready,
  output logic [29:0] fe_pc,
  output logic [31:0] fe_insn,
  output logic        fe_exc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  logic [29:0]   pc_q;
  logic [29:0]   pend_pc_q [DEPTH];
  logic [AW-1:0] pend_rd_q, pend_wr_q;
  logic [CW-1:0] pend_cnt_q, pend_cnt_nxt;
  logic [29:0]   out_pc_q [DEPTH];
  logic [31:0]   out_insn_q [DEPTH];
  logic [AW-1:0] out_rd_q, out_wr_q;
  logic [CW-1:0] out_cnt_q;
  logic [CW-1:0] drop_cnt_q, drop_cnt_nxt;
  logic [CW:0]   credit_used;

  logic redirect, flush, fault_halt;
  logic req_fire, rsp_fire, rsp_drop, out_push, out_pop;

  // Issue gating, response classification and next-state counters.
  always_comb begin
    redirect     = csr_setpc | ex_redirect;
    flush        = csr_kill | ex_redirect;
    credit_used  = {1'b0, pend_cnt_q} + {1'b0, out_cnt_q};
    ic_req_valid = reset_n & ~csr_fe_inhibit & ~redirect & ~csr_kill & ~fault_halt &
                   (credit_used < CREDITS);
    ic_req_pc    = pc_q;
    req_fire     = ic_req_valid & ic_req_ready;
    // Responses with nothing pending are spurious and ignored.
    rsp_fire     = ic_rsp_valid & (pend_cnt_q != '0);
    rsp_drop     = rsp_fire & ((drop_cnt_q != '0) | flush);
    out_push     = rsp_fire & ~rsp_drop;
    fe_valid     = (out_cnt_q != '0);
    out_pop      = fe_valid & fe_ready;
    fe_pc        = out_pc_q[out_rd_q];
    fe_insn      = out_insn_q[out_rd_q];
    pend_cnt_nxt = pend_cnt_q + CW'(req_fire) - CW'(rsp_fire);
    // A flush never coincides with an issue, so pend_cnt_nxt is all older requests.
    if (flush) begin
      drop_cnt_nxt = pend_cnt_nxt;
    end else if (rsp_fire && (drop_cnt_q != '0)) begin
      drop_cnt_nxt = drop_cnt_q - CW'(1);
    end else begin
      drop_cnt_nxt = drop_cnt_q;
    end
  end

  // Fetch PC: csr_setpc beats ex_redirect beats sequential increment.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (csr_setpc) begin
      pc_q <= csr_newpc;
    end else if (ex_redirect) begin
      pc_q <= ex_target;
    end else if (req_fire) begin
      pc_q <= pc_q + 30'd1;
    end
  end

  // Pending-request queue of issued PCs and the stale-response drop counter.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) pend_pc_q[i] <= '0;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      pend_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (req_fire) begin
        pend_pc_q[pend_wr_q] <= pc_q;
        pend_wr_q            <= pend_wr_q + AW'(1);
      end
      if (rsp_fire) pend_rd_q <= pend_rd_q + AW'(1);
      pend_cnt_q <= pend_cnt_nxt;
      drop_cnt_q <= drop_cnt_nxt;
    end
  end

  // Output FIFO towards decode; a flush empties it, overriding any pop.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        out_pc_q[i]   <= '0;
        out_insn_q[i] <= '0;
      end
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (out_push) begin
        out_pc_q[out_wr_q]   <= pend_pc_q[pend_rd_q];
        out_insn_q[out_wr_q] <= ic_rsp_data;
        out_wr_q             <= out_wr_q + AW'(1);
      end
      if (flush) begin
        out_rd_q  <= out_wr_q;
        out_cnt_q <= '0;
      end else begin
        if (out_pop) out_rd_q <= out_rd_q + AW'(1);
        out_cnt_q <= out_cnt_q + CW'(out_push) - CW'(out_pop);
      end
    end
  end

`ifdef FE_IFAULT_EN
  logic fault_halt_q;
  logic out_fault_q [DEPTH];

  // Halt issue once a faulting instruction is buffered; any redirect or kill resumes.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      fault_halt_q <= 1'b0;
    end else if (redirect || csr_kill) begin
      fault_halt_q <= 1'b0;
    end else if (out_push && ic_rsp_fault) begin
      fault_halt_q <= 1'b1;
    end
  end

  // Per-entry fault flag stored alongside the output FIFO data.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) out_fault_q[i] <= 1'b0;
    end else if (out_push) begin
      out_fault_q[out_wr_q] <= ic_rsp_fault;
    end
  end

  assign fault_halt = fault_halt_q;
  assign fe_exc     = fe_valid & out_fault_q[out_rd_q];
`else
  logic unused_fault;

  assign unused_fault = ic_rsp_fault;
  assign fault_halt   = 1'b0;
  assign fe_exc       = 1'b0;
`endif

endmodule

// File: doc/fetch0_pc.md
Name: fetch0_pc

Overview:
- PC sequencer and fetch front end. It is the consumer of the CSR unit's redirect/kill/inhibit outputs and the producer of instruction requests to the I-cache.
- Holds the architectural fetch PC, issues in-order I-cache requests under a credit scheme, and discards responses made stale by kills or redirects.
- Buffers surviving instructions in a small FIFO and presents them to decode through a valid/ready handshake.

Parameters:
- RESET_PC, 30'h0, reset fetch address as word address (PC[31:2]).
- DEPTH, 4, capacity of the pending-request queue and the output FIFO. Power of two, at least 2. Also the credit limit.

Ports:
- clk_core  in  1  core clock
- reset_n  in  1  reset, synchronous, active-low
- csr_kill  in  1  flush all in-flight and buffered fetches
- csr_fe_inhibit  in  1  suppress new requests while high
- csr_setpc  in  1  load PC from csr_newpc
- csr_newpc  in  30  redirect target, PC[31:2]
- ex_redirect  in  1  execute-stage branch/jump redirect; also flushes
- ex_target  in  30  branch target, PC[31:2]
- ic_req_valid  out  1  request valid
- ic_req_ready  in  1  I-cache accepts request
- ic_req_pc  out  30  request address
- ic_rsp_valid  in  1  in-order response; cannot be backpressured
- ic_rsp_data  in  32  instruction word
- ic_rsp_fault  in  1  access fault on the response
- fe_valid  out  1  output FIFO non-empty
- fe_ready  in  1  decode accepts
- fe_pc  out  30  PC of head instruction
- fe_insn  out  32  head instruction
- fe_exc  out  1  head instruction carries an IFAULT

Behaviour:
- Reset values:
  - pc = RESET_PC.
  - Pending queue, output FIFO and drop_cnt all empty/0.
  - fault_halt = 0.
  - ic_req_valid = 0, fe_valid = 0, fe_exc = 0.
  - fe_pc/fe_insn = 0.
- Reset mid-operation discards everything. Any ic_rsp_valid while pending is empty is ignored.
- redirect = csr_setpc | ex_redirect. flush = csr_kill | ex_redirect.
- ic_req_valid = ~csr_fe_inhibit & ~redirect & ~csr_kill & ~fault_halt & (pend_cnt + out_cnt < DEPTH). Combinational, same cycle.
- ic_req_pc = pc.
- Request handshake (valid & ready):
  - push pc into the pending queue.
  - pc <= pc + 1, modulo 2^30; 30'h3FFFFFFF wraps to 0.
- Redirect priority: csr_setpc over ex_redirect over sequential increment.
  - pc is loaded at the edge ending the redirect cycle.
  - No request is issued in that cycle.
- Response (ic_rsp_valid, pending non-empty): pop the pending head.
  - If drop_cnt > 0, or flush is asserted this cycle: discard. drop_cnt decrements if it was non-zero.
  - Otherwise push {pc, data, fault} into the output FIFO.
  - Space in the output FIFO is guaranteed by the credit rule.
- Flush cycle:
  - Output FIFO is emptied, including any simultaneous fe_ready pop.
  - drop_cnt <= pending count after this cycle's pop, so every older outstanding response is discarded.
  - csr_kill alone does not change pc; csr_setpc normally accompanies it.
- Output: fe_valid = out_cnt != 0; head fields are driven from FIFO storage. Pop on fe_valid & fe_ready.
- Simultaneous push and pop on either FIFO in one cycle is legal; the count is unchanged.
- Latency: an I-cache response is visible on fe_valid on the following cycle (registered FIFO write).
- csr_fe_inhibit only gates issue. Responses already in flight still complete and buffer.

Optional Feature:
- Macro FE_IFAULT_EN.
- Defined:
  - ic_rsp_fault is stored per entry and driven on fe_exc.
  - Accepting a faulting response into the output FIFO sets fault_halt, which blocks issue.
  - fault_halt clears on the next redirect or csr_kill.
- Undefined:
  - ic_rsp_fault is ignored.
  - fe_exc is tied 0.
  - fault_halt is constant 0.

Test Plan:
- Reset, then ic_req_ready = 1, fixed-latency cache, fe_ready = 1 → requests 0,1,2,3 in consecutive cycles; fe_pc sequence 0,1,2,3.
- fe_ready = 0, cache always ready → exactly DEPTH = 4 requests issued, then ic_req_valid = 0 until a pop; one pop allows one new request.
- 3 requests outstanding, then csr_kill + csr_setpc with csr_newpc = 30'h40 → drop_cnt = 3; those 3 responses are discarded and fe_valid stays 0; next request and fe_pc = 30'h40.
- csr_setpc and ex_redirect in the same cycle (newpc = 30'h100, target = 30'h200) → next ic_req_pc = 30'h100.
- csr_fe_inhibit held 5 cycles with 2 requests outstanding → no requests issued; both responses appear on fe_valid; issue resumes at the next PC.
- FE_IFAULT_EN: response at pc 30'h8 with ic_rsp_fault = 1 → fe_exc = 1 on that entry; no further requests until csr_setpc; without the macro, fe_exc = 0 and issue continues.
